// File: rtl/rom16_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom16_arbiter
//  Purpose  : Round-robin arbiter sharing one asynchronous 16x8 lookup ROM
//             between two requesters. One read is in flight at a time; each
//             requester has a valid/ready request channel and a valid/ready
//             response channel.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             reqN_valid/addr/ready   - requester N read request (N = 0, 1)
//             rspN_valid/data/ready   - requester N read response
//             rom_ad                  - registered ROM address (owned here)
//             rom_dout                - ROM data, combinational from rom_ad
//             busy                    - high whenever the FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module rom16_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int ROM_WAIT = 1      // edges rom_ad is stable before sampling, 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              busy
);

    localparam int                 c_cnt_w     = 4;
    localparam logic [c_cnt_w-1:0] c_wait_init = c_cnt_w'(ROM_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ptr;        // requester that wins a tie
    logic                r_owner;      // requester of the read in flight
    logic [c_cnt_w-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_rom_ad;
    logic                r_rsp0_valid;
    logic                r_rsp1_valid;
    logic [DATA_W-1:0]   r_rsp0_data;
    logic [DATA_W-1:0]   r_rsp1_data;

    logic                w_gnt_any;
    logic                w_gnt_id;
    logic                w_accept;
    logic                w_sample;
    logic                w_rsp_done;

    // Grant and handshake decode. The pointed-to requester wins a tie; a lone
    // requester is granted regardless of the pointer.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = 1'b0;
        if (r_ptr == 1'b0) begin
            if (req0_valid) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = 1'b0;
            end else if (req1_valid) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = 1'b1;
            end
        end else begin
            if (req1_valid) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = 1'b1;
            end else if (req0_valid) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = 1'b0;
            end
        end
        w_accept   = (r_state == ST_IDLE) && w_gnt_any;
        w_sample   = (r_state == ST_WAIT) && (r_cnt == '0);
        w_rsp_done = (r_state == ST_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_sample)   w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: the address only moves on an accept edge, response data only
    // on the sampling edge, so both hold their last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= 1'b0;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_rom_ad     <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            if (w_accept) begin
                r_rom_ad <= w_gnt_id ? req1_addr : req0_addr;
                r_owner  <= w_gnt_id;
                r_cnt    <= c_wait_init;
                r_ptr    <= ~w_gnt_id;
            end
            if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_sample) begin
                if (r_owner) begin
                    r_rsp1_data  <= rom_dout;
                    r_rsp1_valid <= 1'b1;
                end else begin
                    r_rsp0_data  <= rom_dout;
                    r_rsp0_valid <= 1'b1;
                end
            end
            if (w_rsp_done) begin
                if (r_owner) begin
                    r_rsp1_valid <= 1'b0;
                end else begin
                    r_rsp0_valid <= 1'b0;
                end
            end
        end
    end

    assign req0_ready = w_accept && !w_gnt_id;
    assign req1_ready = w_accept &&  w_gnt_id;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign rom_ad     = r_rom_ad;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rom16_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom16_arbiter
//  Purpose  : Self-checking bench for rom16_arbiter. A table of per-cycle
//             vectors covers single reads, back-to-back reads and contention;
//             hand-written sequences cover response stall, ROM_WAIT=3 and
//             reset in the middle of a read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom16_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [3:0] req0_addr, req1_addr;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [7:0] rsp0_data, rsp1_data, rom_dout;
    logic [3:0] rom_ad;

    // Second instance with a longer ROM wait
    logic       t3_req0_valid, t3_rsp0_ready;
    logic [3:0] t3_req0_addr;
    logic       t3_req1_valid, t3_rsp1_ready;
    logic [3:0] t3_req1_addr;
    logic       t3_req0_ready, t3_req1_ready, t3_rsp0_valid, t3_rsp1_valid, t3_busy;
    logic [7:0] t3_rsp0_data, t3_rsp1_data, t3_rom_dout;
    logic [3:0] t3_rom_ad;

    logic [7:0] rom_mem [16];

    int nchecks = 0;
    int nerrors = 0;

    assign rom_dout    = rom_mem[rom_ad];
    assign t3_rom_dout = rom_mem[t3_rom_ad];

    rom16_arbiter #(.ADDR_W(4), .DATA_W(8), .ROM_WAIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .rom_ad(rom_ad), .rom_dout(rom_dout), .busy(busy)
    );

    rom16_arbiter #(.ADDR_W(4), .DATA_W(8), .ROM_WAIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(t3_req0_valid), .req0_addr(t3_req0_addr), .req0_ready(t3_req0_ready),
        .rsp0_valid(t3_rsp0_valid), .rsp0_data(t3_rsp0_data), .rsp0_ready(t3_rsp0_ready),
        .req1_valid(t3_req1_valid), .req1_addr(t3_req1_addr), .req1_ready(t3_req1_ready),
        .rsp1_valid(t3_rsp1_valid), .rsp1_data(t3_rsp1_data), .rsp1_ready(t3_rsp1_ready),
        .rom_ad(t3_rom_ad), .rom_dout(t3_rom_dout), .busy(t3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Requester protocol: a pending request keeps valid and addr stable.
    logic       r_pend0, r_pend1;
    logic [3:0] r_paddr0, r_paddr1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
        end else begin
            if (r_pend0) chk("proto req0 held", {req0_valid, req0_addr}, {1'b1, r_paddr0});
            if (r_pend1) chk("proto req1 held", {req1_valid, req1_addr}, {1'b1, r_paddr1});
            r_pend0  <= req0_valid && !req0_ready;
            r_pend1  <= req1_valid && !req1_ready;
            r_paddr0 <= req0_addr;
            r_paddr1 <= req1_addr;
        end
    end

    // The two response channels are never valid together.
    always @(negedge clk) begin
        if (rst_n) chk("rsp valid exclusive", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
    end

    typedef struct {
        logic       v0;  logic [3:0] a0; logic r0;
        logic       v1;  logic [3:0] a1; logic r1;
        logic       e_rdy0, e_rdy1;
        logic       e_rv0; logic [7:0] e_d0;
        logic       e_rv1; logic [7:0] e_d1;
        logic [3:0] e_ad;
        logic       e_busy;
    } vec_t;

    function automatic vec_t mk(input int v0, a0, r0, v1, a1, r1, rd0, rd1,
                                rv0, d0, rv1, d1, ad, bz);
        vec_t v;
        v.v0 = 1'(v0); v.a0 = 4'(a0); v.r0 = 1'(r0);
        v.v1 = 1'(v1); v.a1 = 4'(a1); v.r1 = 1'(r1);
        v.e_rdy0 = 1'(rd0); v.e_rdy1 = 1'(rd1);
        v.e_rv0 = 1'(rv0); v.e_d0 = 8'(d0);
        v.e_rv1 = 1'(rv1); v.e_d1 = 8'(d1);
        v.e_ad = 4'(ad); v.e_busy = 1'(bz);
        return v;
    endfunction

    task automatic drive(input logic v0, input logic [3:0] a0, input logic r0,
                         input logic v1, input logic [3:0] a1, input logic r1);
        req0_valid = v0; req0_addr = a0; rsp0_ready = r0;
        req1_valid = v1; req1_addr = a1; rsp1_ready = r1;
    endtask

    localparam int NV = 30;
    vec_t vecs [NV];

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'(8'h10 + i);
        rom_mem[0] = 8'hAA; rom_mem[1] = 8'h55; rom_mem[2] = 8'hF0; rom_mem[9] = 8'h00;

        //            v0 a0 r0 v1 a1 r1 rd0 rd1 rv0 d0     rv1 d1     ad bz
        // single read by requester 0
        vecs[0]  = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 'h00, 0, 'h00, 0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 'h00, 0, 'h00, 0, 1);
        vecs[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 'hAA, 0, 'h00, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'hAA, 0, 'h00, 0, 0);
        // requester 1 back to back: addr 1, 2, 9
        vecs[4]  = mk(0, 0, 0, 1, 1, 1, 0, 1, 0, 'hAA, 0, 'h00, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 2, 1, 0, 0, 0, 'hAA, 0, 'h00, 1, 1);
        vecs[6]  = mk(0, 0, 0, 1, 2, 1, 0, 0, 0, 'hAA, 1, 'h55, 1, 1);
        vecs[7]  = mk(0, 0, 0, 1, 2, 1, 0, 1, 0, 'hAA, 0, 'h55, 1, 0);
        vecs[8]  = mk(0, 0, 0, 1, 9, 1, 0, 0, 0, 'hAA, 0, 'h55, 2, 1);
        vecs[9]  = mk(0, 0, 0, 1, 9, 1, 0, 0, 0, 'hAA, 1, 'hF0, 2, 1);
        vecs[10] = mk(0, 0, 0, 1, 9, 1, 0, 1, 0, 'hAA, 0, 'hF0, 2, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 'hAA, 0, 'hF0, 9, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 'hAA, 1, 'h00, 9, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 'hAA, 0, 'h00, 9, 0);
        // continuous contention: grants 0,1,0,1 then 0 finishes alone
        vecs[14] = mk(1, 0, 1, 1, 2, 1, 1, 0, 0, 'hAA, 0, 'h00, 9, 0);
        vecs[15] = mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 'hAA, 0, 'h00, 0, 1);
        vecs[16] = mk(1, 0, 1, 1, 2, 1, 0, 0, 1, 'hAA, 0, 'h00, 0, 1);
        vecs[17] = mk(1, 0, 1, 1, 2, 1, 0, 1, 0, 'hAA, 0, 'h00, 0, 0);
        vecs[18] = mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 'hAA, 0, 'h00, 2, 1);
        vecs[19] = mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 'hAA, 1, 'hF0, 2, 1);
        vecs[20] = mk(1, 0, 1, 1, 2, 1, 1, 0, 0, 'hAA, 0, 'hF0, 2, 0);
        vecs[21] = mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 'hAA, 0, 'hF0, 0, 1);
        vecs[22] = mk(1, 0, 1, 1, 2, 1, 0, 0, 1, 'hAA, 0, 'hF0, 0, 1);
        vecs[23] = mk(1, 0, 1, 1, 2, 1, 0, 1, 0, 'hAA, 0, 'hF0, 0, 0);
        vecs[24] = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 'hAA, 0, 'hF0, 2, 1);
        vecs[25] = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 'hAA, 1, 'hF0, 2, 1);
        vecs[26] = mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 'hAA, 0, 'hF0, 2, 0);
        vecs[27] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 'hAA, 0, 'hF0, 0, 1);
        vecs[28] = mk(0, 0, 1, 0, 0, 1, 0, 0, 1, 'hAA, 0, 'hF0, 0, 1);
        vecs[29] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 'hAA, 0, 'hF0, 0, 0);

        drive(0, 0, 0, 0, 0, 0);
        t3_req0_valid = 0; t3_req0_addr = 0; t3_rsp0_ready = 0;
        t3_req1_valid = 0; t3_req1_addr = 0; t3_rsp1_ready = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset rom_ad", rom_ad, 0);
        chk("reset busy", busy, 0);
        chk("reset rsp0_valid", rsp0_valid, 0);
        chk("reset rsp1_valid", rsp1_valid, 0);
        chk("reset rsp0_data", rsp0_data, 0);
        chk("reset rsp1_data", rsp1_data, 0);
        chk("reset t3 busy", t3_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].a0, vecs[i].r0, vecs[i].v1, vecs[i].a1, vecs[i].r1);
            #1;
            chk($sformatf("v%0d req0_ready", i), req0_ready, vecs[i].e_rdy0);
            chk($sformatf("v%0d req1_ready", i), req1_ready, vecs[i].e_rdy1);
            chk($sformatf("v%0d rsp0_valid", i), rsp0_valid, vecs[i].e_rv0);
            chk($sformatf("v%0d rsp0_data", i),  rsp0_data,  vecs[i].e_d0);
            chk($sformatf("v%0d rsp1_valid", i), rsp1_valid, vecs[i].e_rv1);
            chk($sformatf("v%0d rsp1_data", i),  rsp1_data,  vecs[i].e_d1);
            chk($sformatf("v%0d rom_ad", i),     rom_ad,     vecs[i].e_ad);
            chk($sformatf("v%0d busy", i),       busy,       vecs[i].e_busy);
        end

        // ---------------- response stall (pointer is at requester 1) ----------------
        @(negedge clk); drive(1, 0, 0, 0, 0, 0); #1;
        chk("stall accept req0_ready", req0_ready, 1);
        @(negedge clk); drive(0, 0, 0, 1, 1, 1); #1;
        chk("stall wait req1_ready", req1_ready, 0);
        chk("stall wait busy", busy, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk($sformatf("stall%0d rsp0_valid", k), rsp0_valid, 1);
            chk($sformatf("stall%0d rsp0_data", k),  rsp0_data,  8'hAA);
            chk($sformatf("stall%0d rom_ad", k),     rom_ad,     0);
            chk($sformatf("stall%0d req1_ready", k), req1_ready, 0);
        end
        @(negedge clk); drive(0, 0, 1, 1, 1, 1); #1;
        chk("stall release rsp0_valid", rsp0_valid, 1);
        @(negedge clk); drive(0, 0, 0, 1, 1, 1); #1;
        chk("stall after rsp0_valid", rsp0_valid, 0);
        chk("stall after req1_ready", req1_ready, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 1); #1;
        chk("stall req1 rom_ad", rom_ad, 1);
        @(negedge clk); #1;
        chk("stall req1 rsp1_valid", rsp1_valid, 1);
        chk("stall req1 rsp1_data", rsp1_data, 8'h55);
        @(negedge clk); #1;
        chk("stall req1 done busy", busy, 0);

        // ---------------- ROM_WAIT = 3 ----------------
        @(negedge clk);
        t3_req0_valid = 1; t3_req0_addr = 4'd1; t3_rsp0_ready = 1; #1;
        chk("w3 accept req0_ready", t3_req0_ready, 1);
        chk("w3 accept busy", t3_busy, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); t3_req0_valid = 0; #1;
            chk($sformatf("w3 wait%0d rsp0_valid", k), t3_rsp0_valid, 0);
            chk($sformatf("w3 wait%0d busy", k), t3_busy, 1);
        end
        @(negedge clk); #1;
        chk("w3 rsp0_valid", t3_rsp0_valid, 1);
        chk("w3 rsp0_data", t3_rsp0_data, 8'h55);
        chk("w3 rom_ad", t3_rom_ad, 1);
        chk("w3 busy resp", t3_busy, 1);
        @(negedge clk); #1;
        chk("w3 done rsp0_valid", t3_rsp0_valid, 0);
        chk("w3 done busy", t3_busy, 0);

        // ---------------- reset during WAIT ----------------
        @(negedge clk); drive(1, 2, 1, 0, 0, 0); #1;
        chk("rst accept req0_ready", req0_ready, 1);
        @(negedge clk); drive(0, 0, 1, 0, 0, 1); #1;
        chk("rst wait busy", busy, 1);
        chk("rst wait rom_ad", rom_ad, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async busy", busy, 0);
        chk("rst async rom_ad", rom_ad, 0);
        chk("rst async rsp0_valid", rsp0_valid, 0);
        chk("rst async rsp0_data", rsp0_data, 0);
        chk("rst async rsp1_data", rsp1_data, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk($sformatf("rst quiet%0d rsp0_valid", k), rsp0_valid, 0);
            chk($sformatf("rst quiet%0d busy", k), busy, 0);
        end
        @(negedge clk); drive(1, 2, 1, 1, 1, 1); #1;
        chk("rst ptr req0_ready", req0_ready, 1);
        chk("rst ptr req1_ready", req1_ready, 0);
        @(negedge clk); drive(0, 0, 1, 1, 1, 1); #1;
        @(negedge clk); #1;
        chk("rst reread rsp0_data", rsp0_data, 8'hF0);
        chk("rst reread rsp0_valid", rsp0_valid, 1);
        @(negedge clk); #1;
        chk("rst req1 granted", req1_ready, 1);
        @(negedge clk); drive(0, 0, 1, 0, 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("final rsp1_data", rsp1_data, 8'h55);
        chk("final busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire
